// File: rtl/tdm_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdm_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int CNT_W     = 3;  // good-sync counter, holds LOCK_FRAMES up to 7

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

    // Slot counter step; the 2-bit width gives the 3 -> 0 wrap for free.
    function automatic slot_t slot_next(input slot_t s);
        return s + slot_t'(1);
    endfunction
endpackage

// File: rtl/tdm_demux1x4_if.sv
// Serial TDM input strobe plus demultiplexed frame and status outputs.
// Latency: n/a (wires only).
// Backpressure: none; the source strobes en, the demux always accepts.
interface tdm_demux1x4_if;
    import tdm_pkg::*;

    logic                 en;
    logic                 din;
    logic                 sync;
    logic [NUM_SLOTS-1:0] Y;
    logic                 frame_valid;
    logic                 locked;
    logic                 sync_err;

    modport master (
        output en, din, sync,
        input  Y, frame_valid, locked, sync_err
    );

    modport slave (
        input  en, din, sync,
        output Y, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_sync_fsm.sv
// Frame-sync tracker: hunts for the marker, qualifies LOCK_FRAMES good syncs, flags violations.
// Latency: state, locked and sync_err change on the edge that samples the strobe.
// Backpressure: none; en=0 freezes all state, sync_err is a one-cycle pulse.
module tdm_sync_fsm
    import tdm_pkg::*;
#(
    parameter int LOCK_FRAMES = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   sync,
    input  slot_t  slot,
    output state_t state,
    output logic   locked,
    output logic   sync_err,
    output logic   frame_start,
    output logic   frame_drop
);
    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_FRAMES);

    logic [CNT_W-1:0] good_cnt;
    logic             at_slot0;

    assign at_slot0 = (slot == '0);

    // Every accepted sync restarts a frame at slot 0, whether expected or misplaced.
    assign frame_start = en && sync;

    // A missing sync at slot 0 while tracking throws away the partial frame.
    assign frame_drop = en && !sync && at_slot0 && (state != HUNT);

    // Lock state machine with registered lock flag and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            good_cnt <= '0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            good_cnt <= CNT_W'(1);
                            if (LOCK_CNT == CNT_W'(1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state  <= ACQUIRE;
                            end
                        end
                    end
                    default: begin
                        if (sync && !at_slot0) begin
                            // Misplaced marker: believe the new position, start counting again.
                            sync_err <= 1'b1;
                            good_cnt <= CNT_W'(1);
                            state    <= ACQUIRE;
                            locked   <= 1'b0;
                        end else if (sync) begin
                            if (good_cnt < LOCK_CNT) begin
                                good_cnt <= good_cnt + CNT_W'(1);
                            end
                            if (good_cnt >= LOCK_CNT - CNT_W'(1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (at_slot0) begin
                            // Expected marker absent: alignment lost.
                            sync_err <= 1'b1;
                            good_cnt <= '0;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/tdm_demux1x4.sv
// 1:4 TDM demultiplexer: collects four strobed serial bits into a frame and presents it on Y.
// Latency: Y and frame_valid update 1 clock after the slot-3 strobe of a locked frame.
// Backpressure: none; en=0 freezes all state, frame_valid is a one-cycle pulse.
module tdm_demux1x4
    import tdm_pkg::*;
#(
    parameter int LOCK_FRAMES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux1x4_if.slave  bus
);
    state_t               state;
    logic                 frame_start;
    logic                 frame_drop;
    slot_t                slot;
    logic [NUM_SLOTS-1:0] buf_q;
    logic [NUM_SLOTS-1:0] y_q;
    logic                 frame_valid_q;

    tdm_sync_fsm #(
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_sync_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (bus.en),
        .sync        (bus.sync),
        .slot        (slot),
        .state       (state),
        .locked      (bus.locked),
        .sync_err    (bus.sync_err),
        .frame_start (frame_start),
        .frame_drop  (frame_drop)
    );

    assign bus.Y           = y_q;
    assign bus.frame_valid = frame_valid_q;

    // Slot counter, frame buffer and output frame register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot          <= '0;
            buf_q         <= '0;
            y_q           <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            if (frame_drop) begin
                slot  <= '0;
                buf_q <= '0;
            end else if (frame_start) begin
                buf_q[0] <= bus.din;
                slot     <= slot_t'(1);
            end else if (bus.en && (state != HUNT)) begin
                buf_q[slot] <= bus.din;
                slot        <= slot_next(slot);
                // Slot 3 completes the frame; only a locked stream is trusted enough to emit.
                if ((state == LOCKED) && (slot == LAST_SLOT)) begin
                    y_q           <= {bus.din, buf_q[NUM_SLOTS-2:0]};
                    frame_valid_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux1x4.sv
// Bench for tdm_demux1x4: LOCK_FRAMES=2 and LOCK_FRAMES=1 instances share one stimulus stream.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_tdm_demux1x4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    tdm_demux1x4_if ifa ();
    tdm_demux1x4_if ifb ();

    tdm_demux1x4 #(.LOCK_FRAMES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    tdm_demux1x4 #(.LOCK_FRAMES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    // Reference model: mode 0 searching, 1 qualifying, 2 locked; pos is the next slot expected.
    typedef struct {
        int       mode;
        int       pos;
        int       good;
        bit [3:0] frame;
        bit [3:0] y;
        bit       fv;
        bit       err;
    } mdl_t;

    typedef struct {
        bit       en;
        bit       din;
        bit       sync;
        bit [3:0] y_a;
        bit       fv_a;
        bit       lk_a;
        bit [3:0] y_b;
        bit       fv_b;
        bit       lk_b;
        bit       err;
    } vec_t;

    mdl_t ma;
    mdl_t mb;
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mode = 0; m.pos = 0; m.good = 0;
        m.frame = 4'b0; m.y = 4'b0; m.fv = 1'b0; m.err = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int lf, input bit en, input bit din, input bit sync);
        mdl_t n = m;
        n.fv  = 1'b0;
        n.err = 1'b0;
        if (en) begin
            if (m.mode == 0) begin
                if (sync) begin
                    n.frame[0] = din; n.pos = 1; n.good = 1; n.mode = (lf == 1) ? 2 : 1;
                end
            end else if (sync && m.pos != 0) begin
                n.err = 1'b1; n.frame[0] = din; n.pos = 1; n.good = 1; n.mode = 1;
            end else if (sync) begin
                n.good = (m.good + 1 > lf) ? lf : m.good + 1;
                if (n.good == lf) n.mode = 2;
                n.frame[0] = din; n.pos = 1;
            end else if (m.pos == 0) begin
                n.err = 1'b1; n.mode = 0; n.good = 0;
            end else begin
                n.frame[m.pos] = din;
                if (m.pos == 3 && m.mode == 2) begin
                    n.y  = {din, m.frame[2], m.frame[1], m.frame[0]};
                    n.fv = 1'b1;
                end
                n.pos = (m.pos + 1) % 4;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare_models();
        check("a_y",    int'(ifa.Y),           int'(ma.y));
        check("a_fv",   int'(ifa.frame_valid), int'(ma.fv));
        check("a_lock", int'(ifa.locked),      int'(ma.mode == 2));
        check("a_err",  int'(ifa.sync_err),    int'(ma.err));
        check("a_excl", int'(ifa.sync_err & ifa.frame_valid), 0);
        check("b_y",    int'(ifb.Y),           int'(mb.y));
        check("b_fv",   int'(ifb.frame_valid), int'(mb.fv));
        check("b_lock", int'(ifb.locked),      int'(mb.mode == 2));
        check("b_err",  int'(ifb.sync_err),    int'(mb.err));
        check("b_excl", int'(ifb.sync_err & ifb.frame_valid), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_y"},    int'(ifa.Y), 0);
        check({tag, "_a_fv"},   int'(ifa.frame_valid), 0);
        check({tag, "_a_lock"}, int'(ifa.locked), 0);
        check({tag, "_a_err"},  int'(ifa.sync_err), 0);
        check({tag, "_b_y"},    int'(ifb.Y), 0);
        check({tag, "_b_lock"}, int'(ifb.locked), 0);
    endtask

    task automatic drive(input bit en, input bit din, input bit sync);
        ifa.en = en; ifa.din = din; ifa.sync = sync;
        ifb.en = en; ifb.din = din; ifb.sync = sync;
    endtask

    // One clock: drive on the falling edge, sample just after the rising edge.
    task automatic apply(input bit en, input bit din, input bit sync);
        @(negedge clk);
        drive(en, din, sync);
        @(posedge clk);
        #1;
        ma = mdl_step(ma, 2, en, din, sync);
        mb = mdl_step(mb, 1, en, din, sync);
        compare_models();
    endtask

    // Four back-to-back strobes, slot k carries bits[k], sync on slot 0.
    task automatic send_frame(input bit [3:0] bits);
        for (int k = 0; k < 4; k++) apply(1'b1, bits[k], k == 0);
    endtask

    vec_t vec[16];

    initial begin
        // Frames 0001, 0010, 0100, 1000 with a sync on every 4th strobe.
        vec[0]  = '{1, 1, 1, 4'b0000, 0, 0, 4'b0000, 0, 1, 0};
        vec[1]  = '{1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0};
        vec[2]  = '{1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0};
        vec[3]  = '{1, 0, 0, 4'b0000, 0, 0, 4'b0001, 1, 1, 0};
        vec[4]  = '{1, 0, 1, 4'b0000, 0, 1, 4'b0001, 0, 1, 0};
        vec[5]  = '{1, 1, 0, 4'b0000, 0, 1, 4'b0001, 0, 1, 0};
        vec[6]  = '{1, 0, 0, 4'b0000, 0, 1, 4'b0001, 0, 1, 0};
        vec[7]  = '{1, 0, 0, 4'b0010, 1, 1, 4'b0010, 1, 1, 0};
        vec[8]  = '{1, 0, 1, 4'b0010, 0, 1, 4'b0010, 0, 1, 0};
        vec[9]  = '{1, 0, 0, 4'b0010, 0, 1, 4'b0010, 0, 1, 0};
        vec[10] = '{1, 1, 0, 4'b0010, 0, 1, 4'b0010, 0, 1, 0};
        vec[11] = '{1, 0, 0, 4'b0100, 1, 1, 4'b0100, 1, 1, 0};
        vec[12] = '{1, 0, 1, 4'b0100, 0, 1, 4'b0100, 0, 1, 0};
        vec[13] = '{1, 0, 0, 4'b0100, 0, 1, 4'b0100, 0, 1, 0};
        vec[14] = '{1, 0, 0, 4'b0100, 0, 1, 4'b0100, 0, 1, 0};
        vec[15] = '{1, 1, 0, 4'b1000, 1, 1, 4'b1000, 1, 1, 0};

        drive(1'b0, 1'b0, 1'b0);
        ma = mdl_reset();
        mb = mdl_reset();

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_zero("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven lock-up scenario.
        for (int i = 0; i < 16; i++) begin
            apply(vec[i].en, vec[i].din, vec[i].sync);
            check($sformatf("tbl%0d_a_y", i),    int'(ifa.Y),           int'(vec[i].y_a));
            check($sformatf("tbl%0d_a_fv", i),   int'(ifa.frame_valid), int'(vec[i].fv_a));
            check($sformatf("tbl%0d_a_lock", i), int'(ifa.locked),      int'(vec[i].lk_a));
            check($sformatf("tbl%0d_b_y", i),    int'(ifb.Y),           int'(vec[i].y_b));
            check($sformatf("tbl%0d_b_fv", i),   int'(ifb.frame_valid), int'(vec[i].fv_b));
            check($sformatf("tbl%0d_b_lock", i), int'(ifb.locked),      int'(vec[i].lk_b));
            check($sformatf("tbl%0d_err", i),    int'(ifa.sync_err),    int'(vec[i].err));
        end

        // Missing sync at slot 0 while locked.
        apply(1'b1, 1'b0, 1'b0);
        check("drop_a_err",  int'(ifa.sync_err), 1);
        check("drop_a_lock", int'(ifa.locked), 0);
        check("drop_a_fv",   int'(ifa.frame_valid), 0);
        check("drop_a_y",    int'(ifa.Y), 4'b1000);
        check("drop_b_err",  int'(ifb.sync_err), 1);

        // Reacquire: first frame only emitted by the single-sync instance.
        send_frame(4'b0101);
        check("reacq1_a_fv", int'(ifa.frame_valid), 0);
        check("reacq1_b_y",  int'(ifb.Y), 4'b0101);
        send_frame(4'b0011);
        check("reacq2_a_y",  int'(ifa.Y), 4'b0011);
        check("reacq2_a_fv", int'(ifa.frame_valid), 1);

        // Misplaced sync at slot 2, relock four strobes later.
        apply(1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        check("mis_a_err",  int'(ifa.sync_err), 1);
        check("mis_a_lock", int'(ifa.locked), 0);
        check("mis_b_lock", int'(ifb.locked), 0);
        repeat (3) apply(1'b1, 1'b0, 1'b0);
        check("mis_a_fv", int'(ifa.frame_valid), 0);
        apply(1'b1, 1'b0, 1'b1);
        check("relock_a_lock", int'(ifa.locked), 1);
        check("relock_a_err",  int'(ifa.sync_err), 0);
        check("relock_b_lock", int'(ifb.locked), 1);

        // Frame 1010 with idle cycles between strobes.
        apply(1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        check("gap_a_y",  int'(ifa.Y), 4'b1010);
        check("gap_a_fv", int'(ifa.frame_valid), 1);
        apply(1'b0, 1'b0, 1'b0);
        check("gap_fv_end", int'(ifa.frame_valid), 0);
        check("gap_y_hold", int'(ifa.Y), 4'b1010);
        check("gap_lock",   int'(ifa.locked), 1);

        // Asynchronous reset mid-frame, between clock edges.
        apply(1'b1, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("rst1");
        drive(1'b0, 1'b0, 1'b0);
        ma = mdl_reset();
        mb = mdl_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(4'b0110);
        check("post_rst1_a_fv", int'(ifa.frame_valid), 0);
        send_frame(4'b1001);
        check("post_rst2_a_y",  int'(ifa.Y), 4'b1001);
        check("post_rst2_a_fv", int'(ifa.frame_valid), 1);

        // Random strobes, mostly well-formed framing with occasional faults.
        for (int i = 0; i < 400; i++) begin
            bit en_r;
            bit sync_r;
            en_r = ($urandom_range(3) != 0);
            if (ma.pos == 0) sync_r = en_r && ($urandom_range(7) != 0);
            else             sync_r = en_r && ($urandom_range(15) == 0);
            apply(en_r, 1'($urandom_range(1)), sync_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
